// File: rtl/rx_fsm.sv
// UART 8N1 receiver: a two-flop synchroniser feeds an FSM that samples mid-bit
// and rebuilds the byte LSB first. A bad stop bit gives a single frame error.
module rx_fsm #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       RSTn,
  input  logic       RX,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       busy,
  output logic [2:0] state_dbg
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t        state;
  logic          rx_m;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  assign state_dbg = state;

  // busy is registered alongside the next state so it equals (state != IDLE)
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data_out  <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_m      <= RX;
      rx_s      <= rx_m;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state <= S_START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        S_START: begin
          if (cnt == CNT_HALF) begin
            if (!rx_s) begin
              state   <= S_DATA;
              cnt     <= '0;
              bit_idx <= '0;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt == CNT_MAX) begin
            shreg   <= {rx_s, shreg[7:1]};
            cnt     <= '0;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (cnt == CNT_MAX) begin
            cnt <= '0;
            if (rx_s) begin
              data_out <= shreg;
              valid    <= 1'b1;
              state    <= S_IDLE;
              busy     <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_BREAK: begin
          // a line held low reports once, then waits here for it to recover
          if (rx_s) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
